// File: rtl/mem_access_ctrl.sv
// Initiator-side controller for the 16x16 word RAM.
// Single/burst reads and writes with per-beat hold windows for the RAM clock.
module mem_access_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int HOLD   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_len,
  output logic              busy,
  output logic              done,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_a,
  input  logic [DATA_W-1:0] mem_q
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WDATA,
    S_ISSUE,
    S_CAPT,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] rdat_q, rdat_d;
  logic              en_q, en_d;
  logic              wrdy_q, wrdy_d;
  logic              rval_q, rval_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    a_d     = a_q;
    rdat_d  = rdat_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          rw_d    = req_rw;
          addr_d  = req_addr;
          cnt_d   = req_len;
          hold_d  = '0;
          state_d = req_rw ? S_ISSUE : S_WDATA;
        end
      end
      S_WDATA: begin
        if (wr_valid) begin
          a_d     = wr_data;
          hold_d  = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (hold_q == HOLD_LAST) begin
          if (rw_q) begin
            rdat_d  = mem_q;
            state_d = S_CAPT;
          end else if (cnt_q == '0) begin
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + 1'b1;
            cnt_d   = cnt_q - 1'b1;
            state_d = S_WDATA;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_CAPT: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + 1'b1;
          cnt_d   = cnt_q - 1'b1;
          hold_d  = '0;
          state_d = S_ISSUE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Strobes are decoded from the next state so they leave a flop.
    en_d   = (state_d == S_ISSUE);
    wrdy_d = (state_d == S_WDATA);
    rval_d = (state_d == S_CAPT);
    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rw_q    <= 1'b1;
      addr_q  <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      a_q     <= '0;
      rdat_q  <= '0;
      en_q    <= 1'b0;
      wrdy_q  <= 1'b0;
      rval_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      a_q     <= a_d;
      rdat_q  <= rdat_d;
      en_q    <= en_d;
      wrdy_q  <= wrdy_d;
      rval_q  <= rval_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign wr_ready = wrdy_q;
  assign rd_data  = rdat_q;
  assign rd_valid = rval_q;
  assign mem_en   = en_q;
  assign mem_rw   = rw_q;
  assign mem_addr = addr_q;
  assign mem_a    = a_q;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator-side controller for the 16x16 word RAM. Accepts single or burst read/write requests from the datapath over a req/busy/done handshake.
- Drives the RAM's en/rw/addr/data-in pins and holds each access stable long enough for the RAM's own free-running clock to sample it.
- Returns read words over a valid-strobe stream and pulls write words through a ready/valid stream.
- Sits between the control unit/datapath and the RAM instance.

Parameters:
DATA_W, 16, word width of RAM data and stream data
ADDR_W, 4, RAM address width (depth 2^ADDR_W = 16)
HOLD, 3, cycles mem_en/mem_rw/mem_addr/mem_a are held stable per beat (min 1); must cover at least one full RAM clock period plus margin

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
req  in  1  start request, sampled only in IDLE
req_rw  in  1  1 = read, 0 = write (same polarity as RAM rw)
req_addr  in  ADDR_W  first beat address
req_len  in  ADDR_W  beats minus one (0 = 1 beat, 15 = 16 beats)
busy  out  1  high from accepted request until done pulse inclusive
done  out  1  one-cycle pulse after last beat completes
wr_data  in  DATA_W  write word
wr_valid  in  1  wr_data valid
wr_ready  out  1  controller accepts a write word this cycle
rd_data  out  DATA_W  captured read word
rd_valid  out  1  one-cycle strobe, rd_data valid
mem_en  out  1  to RAM en
mem_rw  out  1  to RAM rw
mem_addr  out  ADDR_W  to RAM addr
mem_a  out  DATA_W  to RAM data in
mem_q  in  DATA_W  from RAM data out

Behaviour:
- Reset (async, any state):
  - State returns to IDLE; counters cleared.
  - busy=0, done=0, wr_ready=0, rd_valid=0, rd_data=0.
  - mem_en=0, mem_rw=1, mem_addr=0, mem_a=0.
  - An in-flight beat is abandoned; no completion pulse is emitted for it.
- States: IDLE, WDATA, ISSUE, CAPTURE, DONE.
- IDLE:
  - busy=0.
  - On req=1 at an edge: latch req_rw, req_addr into addr register, req_len into beat counter.
  - Next state is WDATA for a write, ISSUE for a read.
  - busy=1 from the next cycle.
- WDATA:
  - wr_ready=1, mem_en=0.
  - On an edge with wr_valid=1: latch wr_data into mem_a, go to ISSUE.
  - wr_valid=0 stalls indefinitely; nothing is driven to the RAM while stalled.
- ISSUE:
  - mem_en=1, mem_rw=latched rw, mem_addr=addr register, and mem_a held constant for exactly HOLD cycles (hold counter).
  - At the end of HOLD cycles: mem_en=0.
  - Read: go to CAPTURE.
  - Write, beat counter=0: go to DONE.
  - Write, beat counter>0: addr+1, counter-1, go to WDATA.
- CAPTURE (read only):
  - rd_data <= mem_q, rd_valid=1 for exactly that one cycle.
  - Beat counter=0: go to DONE.
  - Otherwise: addr+1, counter-1, go to ISSUE.
- DONE: done=1 for one cycle, busy still 1; then IDLE (busy=0 next cycle).
- Address increment wraps modulo 2^ADDR_W (15 -> 0); the burst continues across the wrap.
- req while busy is ignored; the next request is sampled no earlier than the cycle after done.
- wr_valid outside WDATA is ignored and its data discarded.
- Outputs are registered; mem_* never glitch mid-beat.
- Single-read latency (req edge = edge 0):
  - mem_en high for cycles 1..HOLD.
  - rd_valid in cycle HOLD+1.
  - done in cycle HOLD+2.
- Read beats are spaced HOLD+1 cycles apart.
- Single write with wr_valid already high: wr_ready in cycle 1, mem_en for cycles 2..HOLD+1, done in cycle HOLD+2.

Test Plan:
- Reset mid-burst: assert rst during ISSUE of beat 2 of a write burst -> all outputs at reset values immediately, no done pulse; the next req is accepted normally after release.
- Single write then read: write addr 5 data 16'hBEEF, then read addr 5 -> rd_valid exactly once with rd_data=16'hBEEF, each access followed by one done pulse, mem_en high exactly HOLD cycles per access.
- Burst write with wrap: req_addr=14, req_len=3, words 1,2,3,4 with wr_valid gaps of 0/5/0 cycles -> RAM addrs 14,15,0,1 hold 1..4; no mem_en during gaps; read-back burst returns 1,2,3,4 in order with 4 rd_valid strobes.
- Back-pressure and ignored inputs: hold wr_valid=0 for 20 cycles in WDATA -> mem_en stays 0 and busy stays 1. Pulse req during the busy period -> no effect. A stray wr_valid while in IDLE -> no write.
- Full-depth burst read: req_len=15 from addr 0 after filling RAM with addr^16'h00FF -> 16 strobes spaced HOLD+1 cycles, correct data, done in the cycle after the last CAPTURE.
